control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter OPC_W, default 5, SHALL be the opcode width, taken from ir[31:27], and the Operator width.
REQ-002 Parameter IR_W, default 32, SHALL be the instruction register width.
REQ-003 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 clear  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 ir  input  IR_W  SHALL carry the DataPath IR contents; the opcode is ir[31:27].
REQ-006 mem_rdy  input  1  SHALL be the memory-ready strobe; the port SHALL exist only under CU_MEM_WAIT_EN.
REQ-007 run  output  1  SHALL be 1 while the sequencer executes and 0 in HALT.
REQ-008 PCout, Zlowout, MDRout, BAout, Cout  output  1 each  SHALL be the DataPath bus-drive strobes.
REQ-009 MARin, Zin, PCin, MDRin, IRin, Yin  output  1 each  SHALL be the DataPath register-load strobes.
REQ-010 IncPC, Read, Write  output  1 each  SHALL be the PC-increment and memory read/write strobes.
REQ-011 Gra, Grb, Grc, Rin, Rout  output  1 each  SHALL be the register-select and register-file strobes.
REQ-012 Operator  output  OPC_W  SHALL be the ALU operation code; 5'b00011 (ADD) SHALL be used for all address and immediate arithmetic.

Function
REQ-013 States SHALL be RST, T0..T7 and HALT; every output SHALL be a decode of the present state plus the latched opcode only, held for the full cycle, with no intra-cycle delays.
REQ-014 Fetch (all instructions): T0 PCout, MARin, IncPC, Zin; T1 Zlowout, PCin, Read, MDRin; T2 MDRout, IRin.
REQ-015 The opcode SHALL be latched from ir at the end of T2; T3..T7 SHALL decode only the latched value.
REQ-016 ld (00000): T3 Grb, BAout, Yin; T4 Cout, Operator=ADD, Zin; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin; then T0.
REQ-017 ldi (00001): T3 and T4 as for ld; T5 Zlowout, Gra, Rin; then T0.
REQ-018 st (00010): T3..T5 as for ld; T6 Gra, Rout, MDRin, with Read=0; T7 Write; then T0.
REQ-019 add/sub/and/or (00011/00100/00101/00110): T3 Grb, Rout, Yin; T4 Grc, Rout, Operator=opcode, Zin; T5 Zlowout, Gra, Rin; then T0.
REQ-020 addi (01100): T3 Grb, Rout, Yin; T4 Cout, Operator=ADD, Zin; T5 Zlowout, Gra, Rin; then T0.
REQ-021 nop (11010) and every undefined opcode SHALL pass through T3 with all strobes 0, then return to T0.
REQ-022 halt (11011) SHALL go from T3 to HALT; HALT SHALL hold all strobes 0 with run=0 until clear.
REQ-023 No cycle SHALL assert Read and Write together, and no cycle SHALL assert more than one bus-drive strobe (PCout, Zlowout, MDRout, Cout, Rout, BAout).
REQ-024 Cycles per instruction, without CU_MEM_WAIT_EN: ld 8, st 8, ldi 6, addi 6, ALU ops 6, nop 4.

Reset
REQ-025 clear=1 SHALL force state RST, every strobe 0, Operator=0, run=0 and the latched opcode to 0 on the next edge, overriding any state including mid-instruction and HALT.
REQ-026 RST SHALL move to T0 with run=1 on the first edge after clear=0.

Configuration
REQ-027 With CU_MEM_WAIT_EN defined, T1, ld T6 and st T7 SHALL hold their state and strobes while mem_rdy=0 and advance on the first edge with mem_rdy=1; without it, mem_rdy SHALL be absent and each of those states SHALL last one cycle.

Structure
REQ-028 A shared package cu_pkg SHALL hold the opcode constants, ALU_ADD=5'b00011 and the state enumeration.
REQ-029 One sub-module, cu_decode, SHALL map (state, opcode) to the strobe vector; control_unit SHALL hold the state register and opcode latch.

Verification
REQ-030 clear pulse, then ir=ld R1,0x55(R0) -> T0..T7 in 8 cycles; T6 Read=MDRin=1; T7 Gra=Rin=MDRout=1; then T0.
REQ-031 st R1,0x5A(R0) -> T4 Cout=Zin=1, Operator=00011; T6 Gra=Rout=MDRin=1, Read=0; T7 Write=1 only.
REQ-032 sub R3,R1,R2 -> T4 Grc=Rout=Zin=1, Operator=00100; back to T0 after 6 cycles.
REQ-033 halt -> HALT after T3, run=0 for 20 cycles; clear -> RST, then T0 with run=1.
REQ-034 clear asserted in ld T5 -> all strobes 0 next edge; opcode 11111 -> treated as nop, 4 cycles.
REQ-035 CU_MEM_WAIT_EN, mem_rdy=0 for 3 cycles in T1 -> Read=MDRin=1 held 4 cycles, advances when mem_rdy=1; each cycle checked for no Read/Write overlap and at most one bus driver.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcode constants, the ALU add
// code used for address/immediate arithmetic, the sequencer state
// enumeration and the packed strobe vector handed from decode to the top.
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic ba_out;
    logic c_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic inc_pc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobes_t;

  // Register-register ALU instructions that pass their opcode to the ALU.
  function automatic logic is_alu(input logic [4:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
  endfunction

  // Instructions that form base+displacement through BAout.
  function automatic logic is_mem_ref(input logic [4:0] opc);
    return (opc == OP_LD) || (opc == OP_LDI) || (opc == OP_ST);
  endfunction

  // Anything that continues past T3 into the execute states.
  function automatic logic has_execute(input logic [4:0] opc);
    return is_mem_ref(opc) || is_alu(opc) || (opc == OP_ADDI);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Pure combinational decode of (present state, latched opcode) into the
// DataPath strobe vector, the ALU operator and the run flag.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  state_t           state_i,
  input  logic [OPC_W-1:0] opc_i,
  output strobes_t         strobes_o,
  output logic [OPC_W-1:0] operator_o,
  output logic             run_o
);

  logic [4:0] opc;
  assign opc = 5'(opc_i);

  // Table of strobes per state; execute states branch on instruction class.
  always_comb begin
    strobes_o  = '0;
    operator_o = '0;
    run_o      = 1'b1;
    case (state_i)
      ST_T0: begin
        strobes_o.pc_out = 1'b1;
        strobes_o.mar_in = 1'b1;
        strobes_o.inc_pc = 1'b1;
        strobes_o.z_in   = 1'b1;
      end
      ST_T1: begin
        strobes_o.zlow_out = 1'b1;
        strobes_o.pc_in    = 1'b1;
        strobes_o.read     = 1'b1;
        strobes_o.mdr_in   = 1'b1;
      end
      ST_T2: begin
        strobes_o.mdr_out = 1'b1;
        strobes_o.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (is_mem_ref(opc)) begin
          strobes_o.grb    = 1'b1;
          strobes_o.ba_out = 1'b1;
          strobes_o.y_in   = 1'b1;
        end else if (is_alu(opc) || (opc == OP_ADDI)) begin
          strobes_o.grb   = 1'b1;
          strobes_o.r_out = 1'b1;
          strobes_o.y_in  = 1'b1;
        end
      end
      ST_T4: begin
        if (is_alu(opc)) begin
          strobes_o.grc   = 1'b1;
          strobes_o.r_out = 1'b1;
          strobes_o.z_in  = 1'b1;
          operator_o      = opc_i;
        end else if (is_mem_ref(opc) || (opc == OP_ADDI)) begin
          strobes_o.c_out = 1'b1;
          strobes_o.z_in  = 1'b1;
          operator_o      = OPC_W'(ALU_ADD);
        end
      end
      ST_T5: begin
        strobes_o.zlow_out = 1'b1;
        if ((opc == OP_LD) || (opc == OP_ST)) begin
          strobes_o.mar_in = 1'b1;
        end else begin
          strobes_o.gra  = 1'b1;
          strobes_o.r_in = 1'b1;
        end
      end
      ST_T6: begin
        strobes_o.mdr_in = 1'b1;
        if (opc == OP_ST) begin
          strobes_o.gra   = 1'b1;
          strobes_o.r_out = 1'b1;
        end else begin
          strobes_o.read = 1'b1;
        end
      end
      ST_T7: begin
        if (opc == OP_ST) begin
          strobes_o.write = 1'b1;
        end else begin
          strobes_o.mdr_out = 1'b1;
          strobes_o.gra     = 1'b1;
          strobes_o.r_in    = 1'b1;
        end
      end
      default: begin
        run_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit sequencer: owns the state register and the opcode
// latch, and feeds them to cu_decode for the strobes.
// Optional feature macro CU_MEM_WAIT_EN adds the mem_rdy input and stretches
// T1, ld T6 and st T7 until memory signals ready.
module control_unit
  import cu_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter int IR_W  = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [IR_W-1:0]  ir,
`ifdef CU_MEM_WAIT_EN
  input  logic             mem_rdy,
`endif
  output logic             run,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             BAout,
  output logic             Cout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [OPC_W-1:0] Operator
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [OPC_W-1:0] ir_opc;
  logic [4:0]       opc5;
  logic             mem_hold;
  strobes_t         strobes;
  logic             unused_ir_low;

  assign ir_opc        = ir[IR_W-1 -: OPC_W];
  assign unused_ir_low = ^ir[IR_W-OPC_W-1:0];
  assign opc5          = 5'(opc_q);

`ifdef CU_MEM_WAIT_EN
  assign mem_hold = !mem_rdy &&
                    ((state_q == ST_T1) ||
                     ((state_q == ST_T6) && (opc5 == OP_LD)) ||
                     ((state_q == ST_T7) && (opc5 == OP_ST)));
`else
  assign mem_hold = 1'b0;
`endif

  // Next-state and opcode-latch logic; the opcode is captured leaving T2.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (!mem_hold) state_d = ST_T2;
      ST_T2: begin
        state_d = ST_T3;
        opc_d   = ir_opc;
      end
      ST_T3: begin
        if (opc5 == OP_HALT)        state_d = ST_HALT;
        else if (has_execute(opc5)) state_d = ST_T4;
        else                        state_d = ST_T0;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = ((opc5 == OP_LD) || (opc5 == OP_ST)) ? ST_T6 : ST_T0;
      ST_T6:   if (!mem_hold) state_d = ST_T7;
      ST_T7:   if (!mem_hold) state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  // State register and opcode latch with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_RST;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  cu_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .state_i    (state_q),
    .opc_i      (opc_q),
    .strobes_o  (strobes),
    .operator_o (Operator),
    .run_o      (run)
  );

  assign PCout   = strobes.pc_out;
  assign Zlowout = strobes.zlow_out;
  assign MDRout  = strobes.mdr_out;
  assign BAout   = strobes.ba_out;
  assign Cout    = strobes.c_out;
  assign MARin   = strobes.mar_in;
  assign Zin     = strobes.z_in;
  assign PCin    = strobes.pc_in;
  assign MDRin   = strobes.mdr_in;
  assign IRin    = strobes.ir_in;
  assign Yin     = strobes.y_in;
  assign IncPC   = strobes.inc_pc;
  assign Read    = strobes.read;
  assign Write   = strobes.write;
  assign Gra     = strobes.gra;
  assign Grb     = strobes.grb;
  assign Grc     = strobes.grc;
  assign Rin     = strobes.r_in;
  assign Rout    = strobes.r_out;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: a step-counting instruction model predicts
// every cycle's strobes; directed sequences pin literal values, then a
// randomized instruction stream runs against the model.
module tb_control_unit;

  localparam int OPC_W = 5;
  localparam int IR_W  = 32;
`ifdef CU_MEM_WAIT_EN
  localparam bit MEM_WAIT = 1'b1;
`else
  localparam bit MEM_WAIT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             mem_rdy = 1'b1;
  logic [IR_W-1:0]  ir = '0;
  logic             run, PCout, Zlowout, MDRout, BAout, Cout, MARin, Zin, PCin;
  logic             MDRin, IRin, Yin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;
  logic [OPC_W-1:0] Operator;

  always #5 clk = ~clk;

  control_unit #(.OPC_W(OPC_W), .IR_W(IR_W)) dut (
    .clk(clk), .clear(clear), .ir(ir),
`ifdef CU_MEM_WAIT_EN
    .mem_rdy(mem_rdy),
`endif
    .run(run), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout),
    .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .Operator(Operator)
  );

  logic [24:0] dut_vec;
  assign dut_vec = {run, Operator, PCout, Zlowout, MDRout, BAout, Cout, MARin, Zin,
                    PCin, MDRin, IRin, Yin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout};

  localparam logic [18:0] S_PCOUT  = 19'd1 << 18;
  localparam logic [18:0] S_ZLOW   = 19'd1 << 17;
  localparam logic [18:0] S_MDROUT = 19'd1 << 16;
  localparam logic [18:0] S_BAOUT  = 19'd1 << 15;
  localparam logic [18:0] S_COUT   = 19'd1 << 14;
  localparam logic [18:0] S_MARIN  = 19'd1 << 13;
  localparam logic [18:0] S_ZIN    = 19'd1 << 12;
  localparam logic [18:0] S_PCIN   = 19'd1 << 11;
  localparam logic [18:0] S_MDRIN  = 19'd1 << 10;
  localparam logic [18:0] S_IRIN   = 19'd1 << 9;
  localparam logic [18:0] S_YIN    = 19'd1 << 8;
  localparam logic [18:0] S_INCPC  = 19'd1 << 7;
  localparam logic [18:0] S_READ   = 19'd1 << 6;
  localparam logic [18:0] S_WRITE  = 19'd1 << 5;
  localparam logic [18:0] S_GRA    = 19'd1 << 4;
  localparam logic [18:0] S_GRB    = 19'd1 << 3;
  localparam logic [18:0] S_GRC    = 19'd1 << 2;
  localparam logic [18:0] S_RIN    = 19'd1 << 1;
  localparam logic [18:0] S_ROUT   = 19'd1 << 0;
  localparam logic [18:0] BUS_MASK = S_PCOUT | S_ZLOW | S_MDROUT | S_BAOUT | S_COUT | S_ROUT;

  localparam logic [IR_W-1:0] LD_IR   = {5'b00000, 4'd1, 4'd0, 19'h55};
  localparam logic [IR_W-1:0] ST_IR   = {5'b00010, 4'd1, 4'd0, 19'h5A};
  localparam logic [IR_W-1:0] SUB_IR  = {5'b00100, 4'd3, 4'd1, 4'd2, 15'd0};
  localparam logic [IR_W-1:0] HALT_IR = {5'b11011, 27'd0};
  localparam logic [IR_W-1:0] NOP_IR  = {5'b11111, 27'd0};

  int compared   = 0;
  int mismatched = 0;

  // Model: instruction-level view as "step k of an instruction of opcode opc".
  bit         m_rst  = 1'b1;
  bit         m_halt = 1'b0;
  int         m_k    = 0;
  logic [4:0] m_opc  = '0;

  function automatic logic [24:0] lit(input logic [18:0] s, input logic [4:0] op);
    return {1'b1, op, s};
  endfunction

  function automatic int cpi(input logic [4:0] opc);
    if (opc == 5'd0 || opc == 5'd2) return 8;
    if (opc == 5'd1 || opc == 5'd12 || (opc >= 5'd3 && opc <= 5'd6)) return 6;
    return 4;
  endfunction

  function automatic bit mem_step(input logic [4:0] opc, input int k);
    return (k == 1) || (opc == 5'd0 && k == 6) || (opc == 5'd2 && k == 7);
  endfunction

  function automatic logic [24:0] model_vec();
    bit ld, ldi, st, alu, addi;
    logic [18:0] s;
    logic [4:0]  op;
    if (m_rst || m_halt) return 25'd0;
    ld = (m_opc == 5'd0); ldi = (m_opc == 5'd1); st = (m_opc == 5'd2);
    alu = (m_opc >= 5'd3 && m_opc <= 5'd6); addi = (m_opc == 5'd12);
    s = '0; op = '0;
    case (m_k)
      0: s = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
      1: s = S_ZLOW | S_PCIN | S_READ | S_MDRIN;
      2: s = S_MDROUT | S_IRIN;
      3: if (ld || ldi || st) s = S_GRB | S_BAOUT | S_YIN;
         else if (alu || addi) s = S_GRB | S_ROUT | S_YIN;
      4: if (alu) begin s = S_GRC | S_ROUT | S_ZIN; op = m_opc; end
         else begin s = S_COUT | S_ZIN; op = 5'b00011; end
      5: if (ld || st) s = S_ZLOW | S_MARIN;
         else s = S_ZLOW | S_GRA | S_RIN;
      6: if (ld) s = S_READ | S_MDRIN;
         else s = S_GRA | S_ROUT | S_MDRIN;
      7: if (ld) s = S_MDROUT | S_GRA | S_RIN;
         else s = S_WRITE;
      default: s = '0;
    endcase
    return {1'b1, op, s};
  endfunction

  task automatic modelUpdate(input logic clr, input logic [IR_W-1:0] irv, input logic rdy);
    if (clr) begin
      m_rst = 1'b1; m_halt = 1'b0; m_k = 0; m_opc = '0;
    end else if (m_rst) begin
      m_rst = 1'b0; m_k = 0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (MEM_WAIT && mem_step(m_opc, m_k) && !rdy) begin
      m_k = m_k;
    end else begin
      if (m_k == 2) m_opc = irv[31:27];
      if (m_k == 3 && m_opc == 5'b11011) m_halt = 1'b1;
      else if (m_k + 1 >= cpi(m_opc)) m_k = 0;
      else m_k = m_k + 1;
    end
  endtask

  task automatic checkOutput();
    logic [24:0] exp_v;
    exp_v = model_vec();
    compared++;
    if (dut_vec !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL model_cycle k=%0d opc=%b: got %h expected %h", m_k, m_opc, dut_vec, exp_v);
    end
    compared++;
    if ((Read & Write) !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_write_overlap: got Read=%b Write=%b expected not both 1", Read, Write);
    end
    compared++;
    if ($countones(dut_vec[18:0] & BUS_MASK) > 1) begin
      mismatched++;
      $display("[TB] FAIL bus_contention: got drivers %h expected at most one", dut_vec[18:0] & BUS_MASK);
    end
  endtask

  task automatic checkLiteral(input string name, input logic [24:0] exp_v);
    compared++;
    if (dut_vec !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, dut_vec, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [IR_W-1:0] irv, input logic rdy);
    clear   = clr;
    ir      = irv;
    mem_rdy = rdy;
    @(posedge clk);
    modelUpdate(clr, irv, rdy);
    #1;
    checkOutput();
  endtask

  localparam logic [18:0] T0_S = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;

  initial begin
    int halt_cnt;
    logic [4:0] opc;
    logic clr, rdy;
    int pick;

    // Reset, then ld R1,0x55(R0)
    applyStimulus(1'b1, '0, 1'b1);
    checkLiteral("reset_state", 25'd0);
    applyStimulus(1'b0, LD_IR, 1'b1);
    checkLiteral("rst_to_t0", lit(T0_S, 5'd0));
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, LD_IR, 1'b1);
      if (k == 6) checkLiteral("ld_t6", lit(S_READ | S_MDRIN, 5'd0));
      if (k == 7) checkLiteral("ld_t7", lit(S_MDROUT | S_GRA | S_RIN, 5'd0));
    end

    // st R1,0x5A(R0)
    applyStimulus(1'b0, ST_IR, 1'b1);
    checkLiteral("ld_back_to_t0", lit(T0_S, 5'd0));
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, ST_IR, 1'b1);
      if (k == 4) checkLiteral("st_t4", lit(S_COUT | S_ZIN, 5'b00011));
      if (k == 6) checkLiteral("st_t6", lit(S_GRA | S_ROUT | S_MDRIN, 5'd0));
      if (k == 7) checkLiteral("st_t7", lit(S_WRITE, 5'd0));
    end

    // sub R3,R1,R2
    applyStimulus(1'b0, SUB_IR, 1'b1);
    checkLiteral("st_back_to_t0", lit(T0_S, 5'd0));
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, SUB_IR, 1'b1);
      if (k == 4) checkLiteral("sub_t4", lit(S_GRC | S_ROUT | S_ZIN, 5'b00100));
    end

    // halt, idle 20 cycles, clear, restart
    applyStimulus(1'b0, HALT_IR, 1'b1);
    checkLiteral("sub_back_to_t0", lit(T0_S, 5'd0));
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, HALT_IR, 1'b1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, HALT_IR, 1'b1);
      checkLiteral("halt_hold", 25'd0);
    end
    applyStimulus(1'b1, HALT_IR, 1'b1);
    checkLiteral("halt_clear", 25'd0);
    applyStimulus(1'b0, LD_IR, 1'b1);
    checkLiteral("halt_restart_t0", lit(T0_S, 5'd0));

    // clear in ld T5, then undefined opcode 11111 behaves as nop
    for (int k = 1; k <= 5; k++) applyStimulus(1'b0, LD_IR, 1'b1);
    applyStimulus(1'b1, LD_IR, 1'b1);
    checkLiteral("clear_mid_ld", 25'd0);
    applyStimulus(1'b0, NOP_IR, 1'b1);
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, NOP_IR, 1'b1);
    checkLiteral("nop_t3", lit(19'd0, 5'd0));
    applyStimulus(1'b0, NOP_IR, 1'b1);
    checkLiteral("nop_back_to_t0", lit(T0_S, 5'd0));

    if (MEM_WAIT) begin
      applyStimulus(1'b0, LD_IR, 1'b1);
      checkLiteral("wait_t1_enter", lit(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 5'd0));
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, LD_IR, 1'b0);
        checkLiteral("wait_t1_hold", lit(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 5'd0));
      end
      applyStimulus(1'b0, LD_IR, 1'b1);
      checkLiteral("wait_t1_release", lit(S_MDROUT | S_IRIN, 5'd0));
    end

    // Randomized instruction stream against the model
    halt_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pick = int'($urandom_range(0, 10));
      case (pick)
        0: opc = 5'd0;  1: opc = 5'd1;  2: opc = 5'd2;  3: opc = 5'd3;
        4: opc = 5'd4;  5: opc = 5'd5;  6: opc = 5'd6;  7: opc = 5'd12;
        8: opc = 5'd26; 9: opc = 5'd27;
        default: opc = 5'($urandom_range(0, 31));
      endcase
      clr = ($urandom_range(0, 99) == 0) || (halt_cnt > 12);
      rdy = MEM_WAIT ? ($urandom_range(0, 2) != 0) : 1'b1;
      applyStimulus(clr, {opc, 27'($urandom)}, rdy);
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
